// File: rtl/ym_cnt_slot_alu.sv
// ym_cnt_slot_alu: next-value and carry logic for one counter slot (clr > load > inc/dec > hold)
module ym_cnt_slot_alu #(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] val,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] nxt,
   output logic             c_out
);
   logic [WIDTH:0] sum, dif;
   logic           up, dn, ovf;
   always_comb begin
      up    = inc & ~dec;
      dn    = dec & ~inc;
      sum   = {1'b0, val} + (WIDTH+1)'(1);
      dif   = {1'b0, val} - (WIDTH+1)'(1);
      ovf   = (up & sum[WIDTH]) | (dn & dif[WIDTH]);
      // a clamped op in saturate mode simply keeps the boundary value
      nxt   = clr ? '0 : load ? load_val : (ovf && SATURATE != 0) ? val :
              up ? sum[WIDTH-1:0] : dn ? dif[WIDTH-1:0] : val;
      c_out = ~clr & ~load & ovf;
   end
endmodule

// File: rtl/ym_sr_cnt_bank.sv
// ym_sr_cnt_bank: bank of serial up/down counters circulating in a two-phase (c1/c2) shift register
module ym_sr_cnt_bank #(
   parameter  int WIDTH    = 8,
   parameter  int SLOTS    = 24,
   parameter  int SATURATE = 0,
   localparam int SW       = $clog2(SLOTS)
) (
   input  logic             MCLK,
   input  logic             reset,
   input  logic             c1,
   input  logic             c2,
   input  logic             sync,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] val,
   output logic             c_out,
   output logic             zero,
   output logic [SW-1:0]    slot
);
   logic [WIDTH-1:0] v1_q [SLOTS];
   logic [WIDTH-1:0] v1_d [SLOTS];
   logic [WIDTH-1:0] v2_q [SLOTS];
   logic [WIDTH-1:0] v2_d [SLOTS];
   logic [WIDTH-1:0] nxt;
   logic [SW-1:0]    slot_q, slot_d;

   ym_cnt_slot_alu #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_alu (
      .val      (val),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .inc      (inc),
      .dec      (dec),
      .nxt      (nxt),
      .c_out    (c_out)
   );

   assign val  = v2_q[SLOTS-1];
   assign zero = (val == '0);
   assign slot = slot_q;

   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      if (c1) begin
         v1_d[0] = nxt;
         for (int i = 1; i < SLOTS; i++) v1_d[i] = v2_q[i-1];
      end
      if (c2) v2_d = v1_q;
      slot_d = !c2 ? slot_q : (sync || slot_q == SW'(SLOTS-1)) ? '0 : slot_q + SW'(1);
   end

   always_ff @(posedge MCLK) begin
      if (reset) begin
         v1_q   <= '{default: '0};
         v2_q   <= '{default: '0};
         slot_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         slot_q <= slot_d;
      end
   end
endmodule

// File: tb/tb_ym_sr_cnt_bank.sv
// tb_ym_sr_cnt_bank: three bank configurations driven in lockstep and checked against per-slot array models
module tb_ym_sr_cnt_bank;
   logic       clk = 0;
   logic       reset = 1, c1 = 0, c2 = 0, sync = 0, clr = 0, load = 0, inc = 0, dec = 0;
   logic [7:0] load_val = 0;
   logic [3:0] val_a, val_b;
   logic [7:0] val_c;
   logic       co_a, co_b, co_c, z_a, z_b, z_c;
   logic [1:0] sl_a, sl_b;
   logic [4:0] sl_c;

   int n_cmp = 0, n_err = 0;
   int ma[3], mb[3], mc[24];
   int pos3 = 0, pos24 = 0, slot3 = 0, slot24 = 0;
   int na, nb, nc;
   bit ca, cb, cc;
   int seq[3] = '{5, 9, 12};

   always #5 clk = ~clk;

   ym_sr_cnt_bank #(.WIDTH(4), .SLOTS(3), .SATURATE(0)) dut_a (
      .MCLK(clk), .reset(reset), .c1(c1), .c2(c2), .sync(sync), .clr(clr), .load(load),
      .load_val(load_val[3:0]), .inc(inc), .dec(dec), .val(val_a), .c_out(co_a), .zero(z_a), .slot(sl_a));
   ym_sr_cnt_bank #(.WIDTH(4), .SLOTS(3), .SATURATE(1)) dut_b (
      .MCLK(clk), .reset(reset), .c1(c1), .c2(c2), .sync(sync), .clr(clr), .load(load),
      .load_val(load_val[3:0]), .inc(inc), .dec(dec), .val(val_b), .c_out(co_b), .zero(z_b), .slot(sl_b));
   ym_sr_cnt_bank dut_c (
      .MCLK(clk), .reset(reset), .c1(c1), .c2(c2), .sync(sync), .clr(clr), .load(load),
      .load_val(load_val), .inc(inc), .dec(dec), .val(val_c), .c_out(co_c), .zero(z_c), .slot(sl_c));

   function automatic void model_op(input int v, input int w, input bit sat, output int n, output bit co);
      int mx;
      mx = (1 << w) - 1;
      n  = v;
      co = 0;
      if (clr) n = 0;
      else if (load) n = int'(load_val) & mx;
      else if (inc && !dec) begin
         if (v == mx) begin co = 1; n = sat ? mx : 0; end else n = v + 1;
      end else if (dec && !inc) begin
         if (v == 0) begin co = 1; n = sat ? 0 : mx; end else n = v - 1;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ops(input bit cl, input bit ld, input logic [7:0] lv, input bit in, input bit de);
      clr = cl; load = ld; load_val = lv; inc = in; dec = de;
      #1;
      model_op(ma[pos3], 4, 0, na, ca);
      model_op(mb[pos3], 4, 1, nb, cb);
      model_op(mc[pos24], 8, 0, nc, cc);
      check("A val", val_a, ma[pos3]);   check("A c_out", co_a, ca);
      check("A zero", z_a, ma[pos3] == 0); check("A slot", sl_a, slot3);
      check("B val", val_b, mb[pos3]);   check("B c_out", co_b, cb);
      check("B zero", z_b, mb[pos3] == 0); check("B slot", sl_b, slot3);
      check("C val", val_c, mc[pos24]);  check("C c_out", co_c, cc);
      check("C zero", z_c, mc[pos24] == 0); check("C slot", sl_c, slot24);
   endtask

   task automatic commit(input bit s, input bit idle);
      c1 = 1;
      @(posedge clk); #1;
      c1 = 0; clr = 0; load = 0; inc = 0; dec = 0;
      ma[pos3] = na; mb[pos3] = nb; mc[pos24] = nc;
      if (idle) begin @(posedge clk); #1; end
      c2 = 1; sync = s;
      @(posedge clk); #1;
      c2 = 0; sync = 0;
      pos3   = (pos3 + 1) % 3;
      pos24  = (pos24 + 1) % 24;
      slot3  = (s || slot3 == 2) ? 0 : slot3 + 1;
      slot24 = (s || slot24 == 23) ? 0 : slot24 + 1;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) begin ops(0, 0, 0, 0, 0); commit(0, 0); end
   endtask

   task automatic model_reset();
      ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
      pos3 = 0; pos24 = 0; slot3 = 0; slot24 = 0;
   endtask

   task automatic rand_tick(input bit allow_sync);
      int r;
      r = $urandom_range(0, 15);
      ops(r == 0, r == 1 || r == 2, 8'($urandom), 1'($urandom), 1'($urandom));
      commit(allow_sync && $urandom_range(0, 15) == 0, 1'($urandom));
   endtask

   initial begin
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      ops(0, 0, 0, 0, 0);
      check("reset zero", z_a, 1);
      check("reset slot", sl_c, 0);

      // loads into consecutive slots come back in order, one per tick
      ops(0, 1, 5, 0, 0);  commit(0, 0);
      ops(0, 1, 9, 0, 0);  commit(0, 0);
      ops(0, 1, 12, 0, 0); commit(0, 0);
      for (int i = 0; i < 3; i++) begin
         ops(0, 0, 0, 0, 0);
         check("seq val", val_a, seq[i]);
         check("seq slot", sl_a, i);
         commit(0, 0);
      end

      // wrap vs saturate at the top
      ops(0, 1, 15, 0, 0); commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 1, 0);
      check("A inc15 c_out", co_a, 1);
      check("B inc15 c_out", co_b, 1);
      commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 0, 0);
      check("A wrap to 0", val_a, 0);
      check("B held 15", val_b, 15);
      commit(0, 0); idle_ticks(2);

      // wrap vs saturate at the bottom
      ops(0, 1, 0, 0, 0); commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 0, 1);
      check("A dec0 c_out", co_a, 1);
      check("B dec0 c_out", co_b, 1);
      commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 0, 0);
      check("A wrap to 15", val_a, 15);
      check("B held 0", val_b, 0);
      commit(0, 0); idle_ticks(2);

      ops(0, 1, 7, 0, 0); commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 1, 1);
      check("B inc&dec c_out", co_b, 0);
      commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 0, 0);
      check("B inc&dec hold", val_b, 7);
      commit(0, 0);

      // clr beats load and inc on one slot
      ops(0, 1, 6, 0, 0); commit(0, 0);
      ops(0, 1, 4, 0, 0); commit(0, 0); idle_ticks(1);
      ops(1, 1, 3, 1, 0);
      check("clr c_out", co_a, 0);
      commit(0, 0); idle_ticks(2);
      ops(0, 0, 0, 0, 0);
      check("clr slot val", val_a, 0);
      commit(0, 0);
      ops(0, 0, 0, 0, 0);
      check("neighbour kept", val_a, 4);
      commit(0, 0);

      for (int i = 0; i < 60; i++) rand_tick(1);

      // sync ignored while c2 is low
      ops(0, 0, 0, 0, 0);
      sync = 1;
      @(posedge clk); #1;
      sync = 0;
      ops(0, 0, 0, 0, 0);
      commit(0, 0);

      for (int i = 0; i < 30 && slot24 != 10; i++) rand_tick(0);
      ops(0, 0, 0, 0, 0);
      check("C at slot 10", sl_c, 10);
      commit(1, 0);
      ops(0, 0, 0, 0, 0);
      check("C sync to 0", sl_c, 0);
      commit(0, 0);

      for (int i = 0; i < 30 && slot24 != 23; i++) rand_tick(0);
      ops(0, 0, 0, 0, 0);
      check("C at slot 23", sl_c, 23);
      commit(0, 0);
      ops(0, 0, 0, 0, 0);
      check("C wrap to 0", sl_c, 0);
      commit(0, 0);

      // reset between c1 and c2 wins over the c2 in its cycle
      ops(0, 1, 9, 0, 0);
      c1 = 1;
      @(posedge clk); #1;
      c1 = 0; load = 0;
      reset = 1; c2 = 1; sync = 1;
      @(posedge clk); #1;
      reset = 0; c2 = 0; sync = 0;
      model_reset();
      ops(0, 0, 0, 0, 0);
      check("midtick val", val_c, 0);
      check("midtick zero", z_c, 1);
      check("midtick slot", sl_a, 0);
      commit(0, 0);

      for (int i = 0; i < 40; i++) rand_tick(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
